// File: rtl/culsans_exit_unit_if.sv
// Request/response bus of the exit unit: req/gnt handshake with a one-cycle registered response.
interface culsans_exit_unit_if #(
    parameter int unsigned AddrWidth = 64
);
    logic                 req_i;
    logic                 we_i;
    logic [AddrWidth-1:0] addr_i;
    logic [63:0]          wdata_i;
    logic [7:0]           be_i;
    logic                 gnt_o;
    logic                 rvalid_o;
    logic [63:0]          rdata_o;
    logic                 err_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/culsans_exit_unit.sv
// HTIF-style exit unit: tohost/fromhost registers, sticky exit code, optional watchdog.
module culsans_exit_unit #(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned TimeoutCycles = 0,
    parameter logic [31:0] TimeoutCode   = 32'h0000_DEAD
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    culsans_exit_unit_if.slave bus,
    output logic [31:0]        exit_o
);
    localparam bit          WdEn   = (TimeoutCycles != 0);
    localparam logic [31:0] WdLast = WdEn ? 32'(TimeoutCycles - 1) : 32'h0;

    typedef enum logic {RUN, EXITED} state_e;

    state_e      state_q;
    logic [63:0] tohost_q, fromhost_q;
    logic [31:0] cnt_q;
    logic [63:0] cur, bmask, merged;
    logic        sel_to, sel_from, addr_ok, exit_wr, wd_fire;
    logic        unused_addr;

    // Upper address bits are decoded outside this block.
    assign unused_addr = ^bus.addr_i[AddrWidth-1:4];

    assign bus.gnt_o = bus.req_i;
    assign sel_to    = (bus.addr_i[3:0] == 4'h0);
    assign sel_from  = (bus.addr_i[3:0] == 4'h8);
    assign addr_ok   = sel_to | sel_from;
    assign cur       = sel_to ? tohost_q : fromhost_q;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < 8; b++) bmask[b*8 +: 8] = {8{bus.be_i[b]}};
    end

    assign merged  = (cur & ~bmask) | (bus.wdata_i & bmask);
    assign exit_wr = bus.req_i & bus.we_i & sel_to & merged[0];
    assign wd_fire = WdEn && (cnt_q == WdLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            tohost_q     <= '0;
            fromhost_q   <= '0;
            cnt_q        <= '0;
            exit_o       <= '0;
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= '0;
            bus.err_o    <= 1'b0;
        end else begin
            bus.rvalid_o <= bus.req_i;
            bus.rdata_o  <= '0;
            bus.err_o    <= 1'b0;
            if (bus.req_i) begin
                bus.err_o <= ~addr_ok;
                // Reads see the pre-write value; writes answer with zero data.
                if (!bus.we_i && addr_ok) bus.rdata_o <= cur;
                if (bus.we_i && sel_to)   tohost_q    <= merged;
                if (bus.we_i && sel_from) fromhost_q  <= merged;
            end
            case (state_q)
                RUN: begin
                    cnt_q <= cnt_q + 32'd1;
                    // A software exit in the same cycle as expiry takes priority.
                    if (exit_wr) begin
                        exit_o  <= merged[31:0];
                        state_q <= EXITED;
                    end else if (wd_fire) begin
                        exit_o  <= {TimeoutCode[30:0], 1'b1};
                        state_q <= EXITED;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
